axi_bresp_gen: RTL

AXI_BRESP_GEN -- requirements
Module: axi_bresp_gen

---
 rtl/axi_bresp_pkg.sv | 32 +++
 rtl/bresp_aw_fifo.sv | 61 ++++++
 rtl/axi_bresp_gen.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/axi_bresp_pkg.sv
// Shared definitions for the AXI3 write-response generator.
// Holds the AW queue geometry, the AXI field widths, the B response encodings
// and the packed layout of one queued AW request.
package axi_bresp_pkg;

  // AW queue geometry
  localparam int FIFO_DEPTH = 4;
  localparam int PTR_W      = 2;
  localparam int CNT_W      = PTR_W + 1;  // occupancy 0..FIFO_DEPTH

  // AXI field widths
  localparam int ID_W       = 8;
  localparam int LEN_W      = 4;
  localparam int BEAT_W     = 5;          // beat count up to 16 plus wrap room
  localparam int ENTRY_W    = ID_W + LEN_W;

  // B response encodings
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // One queued AW request
  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [LEN_W-1:0] len;
  } aw_entry_t;

  // Number of beats an AXI3 burst carries for a given awlen (awlen + 1).
  function automatic logic [BEAT_W-1:0] burst_beats(input logic [LEN_W-1:0] len);
    burst_beats = {1'b0, len} + BEAT_W'(1);
  endfunction

endpackage

// File: rtl/bresp_aw_fifo.sv
// In-order queue of accepted AW requests.
// Push and pop are independent and may happen in the same cycle. A push while
// full or a pop while empty is ignored, so the occupancy can never leave 0..4.
// full/empty come straight from registered occupancy: there is no bypass path,
// a same-cycle pop does not free a slot for a same-cycle push.
module bresp_aw_fifo
  import axi_bresp_pkg::*;
(
  input  logic               clk,
  input  logic               rst_b,
  input  logic               push,
  input  logic [ENTRY_W-1:0] push_data,
  input  logic               pop,
  output logic               full,
  output logic               empty,
  output logic [ENTRY_W-1:0] head
);

  aw_entry_t        mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Storage array: written on an accepted push, no reset needed since reads
  // are only meaningful while the occupancy says the slot is live.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= aw_entry_t'(push_data);
    end
  end

  // Pointers and occupancy: pointers wrap naturally at the depth.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/axi_bresp_gen.sv
// AXI3 write-response generator.
// Queues AW requests, counts W beats of the head burst and, on the accepted
// wlast beat, retires the head and loads a B response register.
//
// Handshake rules: every channel transfers on a rising edge where valid and
// ready are both high. valid never depends on ready; awready depends only on
// queue occupancy, and wready depends on occupancy plus bready (a W burst may
// only finish when the B register is free or being emptied that same cycle).
//
// Build option: define AXI_BRESP_GEN_CHECK_EN to enable per-burst checking
// (wid against the head awid, beat count against awlen+1); failing bursts are
// answered with SLVERR. Without it bresp is constantly OKAY and wid is unused.
module axi_bresp_gen
  import axi_bresp_pkg::*;
(
  input  logic             per_clk,
  input  logic             pad_cpu_rst_b,
  input  logic             biu_pad_awvalid,
  output logic             pad_biu_awready,
  input  logic [ID_W-1:0]  biu_pad_awid,
  input  logic [LEN_W-1:0] biu_pad_awlen,
  input  logic             biu_pad_wvalid,
  output logic             pad_biu_wready,
  input  logic [ID_W-1:0]  biu_pad_wid,
  input  logic             biu_pad_wlast,
  output logic             pad_biu_bvalid,
  input  logic             biu_pad_bready,
  output logic [ID_W-1:0]  pad_biu_bid,
  output logic [1:0]       pad_biu_bresp
);

  logic              fifo_full;
  logic              fifo_empty;
  logic [ENTRY_W-1:0] head_raw;
  aw_entry_t         head;
  aw_entry_t         push_entry;
  logic              aw_hs;
  logic              w_hs;
  logic              wlast_hs;
  logic [BEAT_W-1:0] beat_cnt;
  logic              bvalid_q;
  logic [ID_W-1:0]   bid_q;

  assign push_entry = '{id: biu_pad_awid, len: biu_pad_awlen};
  assign head       = aw_entry_t'(head_raw);

  assign pad_biu_awready = ~fifo_full;
  assign pad_biu_wready  = ~fifo_empty & ~(bvalid_q & ~biu_pad_bready);

  assign aw_hs    = biu_pad_awvalid & pad_biu_awready;
  assign w_hs     = biu_pad_wvalid & pad_biu_wready;
  assign wlast_hs = w_hs & biu_pad_wlast;

  assign pad_biu_bvalid = bvalid_q;
  assign pad_biu_bid    = bid_q;

  bresp_aw_fifo u_aw_fifo (
    .clk       (per_clk),
    .rst_b     (pad_cpu_rst_b),
    .push      (aw_hs),
    .push_data (ENTRY_W'(push_entry)),
    .pop       (wlast_hs),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (head_raw)
  );

  // Beat counter for the head burst: counts accepted beats, clears on wlast.
  // It is intentionally unsaturated; overlong bursts just wrap it.
  always_ff @(posedge per_clk or negedge pad_cpu_rst_b) begin
    if (!pad_cpu_rst_b) begin
      beat_cnt <= '0;
    end else if (wlast_hs) begin
      beat_cnt <= '0;
    end else if (w_hs) begin
      beat_cnt <= beat_cnt + BEAT_W'(1);
    end
  end

  // B valid/id register: loaded on wlast, held until bready, reloaded
  // back-to-back when a wlast coincides with the B handshake.
  always_ff @(posedge per_clk or negedge pad_cpu_rst_b) begin
    if (!pad_cpu_rst_b) begin
      bvalid_q <= 1'b0;
      bid_q    <= '0;
    end else if (wlast_hs) begin
      bvalid_q <= 1'b1;
      bid_q    <= head.id;
    end else if (bvalid_q && biu_pad_bready) begin
      bvalid_q <= 1'b0;
    end
  end

`ifdef AXI_BRESP_GEN_CHECK_EN

  logic       err_q;
  logic       id_mismatch;
  logic       len_mismatch;
  logic       burst_err;
  logic [1:0] bresp_q;

  // id_mismatch is qualified by w_hs wherever it is used; len_mismatch only
  // matters on the wlast beat, where beat_cnt+1 is the full burst length.
  assign id_mismatch  = (biu_pad_wid != head.id);
  assign len_mismatch = ((beat_cnt + BEAT_W'(1)) != burst_beats(head.len));
  assign burst_err    = err_q | id_mismatch | len_mismatch;

  // Sticky per-burst error flag: set by any mismatched non-final beat,
  // cleared as the burst retires.
  always_ff @(posedge per_clk or negedge pad_cpu_rst_b) begin
    if (!pad_cpu_rst_b) begin
      err_q <= 1'b0;
    end else if (wlast_hs) begin
      err_q <= 1'b0;
    end else if (w_hs && id_mismatch) begin
      err_q <= 1'b1;
    end
  end

  // Response code register, loaded alongside bid on the wlast beat.
  always_ff @(posedge per_clk or negedge pad_cpu_rst_b) begin
    if (!pad_cpu_rst_b) begin
      bresp_q <= RESP_OKAY;
    end else if (wlast_hs) begin
      bresp_q <= burst_err ? RESP_SLVERR : RESP_OKAY;
    end
  end

  assign pad_biu_bresp = bresp_q;

`else

  logic unused_check_inputs;

  // Without checking, wid, the queued awlen and the beat count feed nothing.
  assign unused_check_inputs = ^{biu_pad_wid, head.len, beat_cnt};
  assign pad_biu_bresp       = RESP_OKAY;

`endif

endmodule
